// File: rtl/gpio_exp_pkg.sv
// ============================================================================
// Module   : gpio_exp_pkg
// Brief    : Shared types and helpers for the GPIO bank APB arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_exp_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    // Wait-state budget used when the integrator does not override it
    localparam int c_default_timeout = 16;

    // Width of a bank index: at least one bit even for a two-bank system
    function automatic int bank_idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_arb2.sv
// ============================================================================
// Module   : apb_rr_arb2
// Brief    : Two-way round-robin arbiter; grant is combinational, the
//            last-grant pointer advances only when a grant is issued.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arb2 (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic       r_last;     // 1 = requester 1 was served most recently
    logic [1:0] w_gnt;

    // Single requester wins outright; a tie goes to the one not served last
    always_comb begin
        w_gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                w_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                w_gnt = req;
            end
        end
    end

    assign gnt = w_gnt;

    // Track the last winner; reset points at requester 1 so requester 0 wins the first tie
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_last <= 1'b1;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_bank_arbiter.sv
// ============================================================================
// Module   : apb_bank_arbiter
// Brief    : Shares one APB GPIO bank bus between two requesters, round-robin,
//            with a bounded wait-state timeout and per-requester done/err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_bank_arbiter
    import gpio_exp_pkg::*;
#(
    parameter  int BANK_NUM   = 2,
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 3,
    parameter  int TIMEOUT    = c_default_timeout,
    localparam int c_biw      = bank_idx_width(BANK_NUM)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [c_biw-1:0]      m0_bank,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [c_biw-1:0]      m1_bank,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [BANK_NUM-1:0]   psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    localparam int                  c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [31:0]         c_bank_lim = BANK_NUM;
    localparam logic [BANK_NUM-1:0] c_psel_one = BANK_NUM'(1);

    arb_state_t            r_state;
    logic                  r_owner;     // 0 = m0 owns the transfer, 1 = m1
    logic [c_cnt_w-1:0]    r_cnt;
    logic [BANK_NUM-1:0]   r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_m0_done;
    logic                  r_m1_done;
    logic                  r_m0_err;
    logic                  r_m1_err;

    logic [1:0]            w_gnt;
    logic                  w_sel_write;
    logic [c_biw-1:0]      w_sel_bank;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_bank_ok;

    apb_rr_arb2 u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     ({m1_req, m0_req}),
        .en      (r_state == ST_IDLE),
        .gnt     (w_gnt)
    );

    // Pick the granted requester's transfer fields
    always_comb begin
        w_sel_write = m0_write;
        w_sel_bank  = m0_bank;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_gnt[1]) begin
            w_sel_write = m1_write;
            w_sel_bank  = m1_bank;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
        w_bank_ok = (32'(w_sel_bank) < c_bank_lim);
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_cnt     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_err  <= 1'b0;
        end else begin
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_owner <= w_gnt[1];
                        if (w_bank_ok) begin
                            r_state  <= ST_SETUP;
                            r_psel   <= c_psel_one << w_sel_bank;
                            r_pwrite <= w_sel_write;
                            r_paddr  <= w_sel_addr;
                            r_pwdata <= w_sel_wdata;
                            r_cnt    <= '0;
                        end else begin
                            // Nonexistent bank: answer with an error, never touch the bus
                            r_state   <= ST_RESP;
                            r_m0_done <= w_gnt[0];
                            r_m1_done <= w_gnt[1];
                            r_m0_err  <= w_gnt[0];
                            r_m1_err  <= w_gnt[1];
                        end
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    // pready on the last allowed cycle still counts as success
                    if (pready || (r_cnt == c_cnt_last)) begin
                        r_state   <= ST_RESP;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                        r_m0_done <= ~r_owner;
                        r_m1_done <= r_owner;
                        r_m0_err  <= ~r_owner & ~pready;
                        r_m1_err  <= r_owner & ~pready;
                        if (pready && !r_pwrite) begin
                            r_rdata <= prdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // One quiet cycle lets the finished requester drop req
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
    assign rdata   = r_rdata;
    assign m0_done = r_m0_done;
    assign m1_done = r_m1_done;
    assign m0_err  = r_m0_err;
    assign m1_err  = r_m1_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_bank_arbiter.sv
// ============================================================================
// Module   : tb_apb_bank_arbiter
// Brief    : Self-checking bench for apb_bank_arbiter: directed scenarios plus
//            a randomized run against a transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_bank_arbiter;

    localparam int TO = 16;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       m0_req, m0_write, m0_bank, m1_req, m1_write, m1_bank;
    logic [2:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       pready;
    logic [7:0] prdata;
    logic       m0_done, m0_err, m1_done, m1_err, penable, pwrite;
    logic [7:0] rdata, pwdata;
    logic [1:0] psel;
    logic [2:0] paddr;

    // Three-bank instance for the out-of-range bank case
    logic       m1_req3;
    logic [1:0] m1_bank3;
    logic       m0_done3, m0_err3, m1_done3, m1_err3, penable3, pwrite3;
    logic [7:0] rdata3, pwdata3;
    logic [2:0] psel3, paddr3;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_bank_arbiter #(.BANK_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .m0_req(m0_req), .m0_write(m0_write), .m0_bank(m0_bank), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_bank(m1_bank), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m1_done(m1_done), .m1_err(m1_err), .rdata(rdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    apb_bank_arbiter #(.BANK_NUM(3), .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(TO)) dut3 (
        .pclk(pclk), .presetn(presetn),
        .m0_req(1'b0), .m0_write(1'b0), .m0_bank(2'b00), .m0_addr(3'b000), .m0_wdata(8'h00),
        .m1_req(m1_req3), .m1_write(m1_write), .m1_bank(m1_bank3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_done(m0_done3), .m0_err(m0_err3), .m1_done(m1_done3), .m1_err(m1_err3), .rdata(rdata3),
        .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
        .prdata(prdata), .pready(pready)
    );

    task automatic clear_inputs();
        m0_req = 0; m0_write = 0; m0_bank = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_bank = 0; m1_addr = 0; m1_wdata = 0;
        pready = 0; prdata = 0; m1_req3 = 0; m1_bank3 = 0;
    endtask

    // Leaves the bench at the falling edge of the first IDLE cycle (cycle 0)
    task automatic do_reset();
        presetn = 0;
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        presetn = 0; m0_req = 1; m1_req = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            checks++;
            if ({psel, penable, pwrite, paddr, pwdata} !== 15'd0) begin
                errors++; $display("FAIL reset_apb: got %h exp 0", {psel, penable, pwrite, paddr, pwdata});
            end
            checks++;
            if ({rdata, m0_done, m1_done, m0_err, m1_err} !== 12'd0) begin
                errors++; $display("FAIL reset_resp: got %h exp 0", {rdata, m0_done, m1_done, m0_err, m1_err});
            end
        end
        clear_inputs();
        presetn = 1;
    endtask

    task automatic test_single_write();
        do_reset();
        m0_req = 1; m0_write = 1; m0_bank = 1; m0_addr = 3'd5; m0_wdata = 8'hA5; pready = 1;
        @(negedge pclk);   // cycle 1: SETUP
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {2'b10, 1'b0, 1'b1, 3'd5, 8'hA5}) begin
            errors++; $display("FAIL sw_setup: got psel=%b en=%b wr=%b addr=%0d wd=%h exp 10/0/1/5/a5", psel, penable, pwrite, paddr, pwdata);
        end
        m0_addr = 3'd2; m0_wdata = 8'h00; m0_write = 0; m0_bank = 0;   // must be ignored now
        @(negedge pclk);   // cycle 2: ACCESS
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {2'b10, 1'b1, 1'b1, 3'd5, 8'hA5}) begin
            errors++; $display("FAIL sw_access: got psel=%b en=%b wr=%b addr=%0d wd=%h exp 10/1/1/5/a5", psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge pclk);   // cycle 3: RESP
        checks++;
        if ({m0_done, m0_err, m1_done, m1_err} !== 4'b1000) begin
            errors++; $display("FAIL sw_done: got %b exp 1000", {m0_done, m0_err, m1_done, m1_err});
        end
        m0_req = 0;
        @(negedge pclk);   // cycle 4: IDLE
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, m0_done} !== 16'd0) begin
            errors++; $display("FAIL sw_idle: got %h exp 0", {psel, penable, pwrite, paddr, pwdata, m0_done});
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int k;
        do_reset();
        m0_req = 1; m0_write = 1; m0_bank = 0; m0_addr = 3'd1; m0_wdata = 8'h11;
        m1_req = 1; m1_write = 1; m1_bank = 1; m1_addr = 3'd2; m1_wdata = 8'h22;
        pready = 1;
        for (int t = 1; t <= 16; t++) begin
            @(negedge pclk);
            if (m0_done || m1_done) begin
                checks++;
                if ({m1_done, m0_done} !== ((ndone % 2 == 0) ? 2'b01 : 2'b10) || t != 3 + 4 * ndone) begin
                    errors++; $display("FAIL b2b_order: done#%0d at cycle %0d m1/m0=%b exp cycle %0d owner m%0d", ndone, t, {m1_done, m0_done}, 3 + 4 * ndone, ndone % 2);
                end
                ndone++;
            end
            if (psel != 2'b00 && !penable) begin
                k = (t - 1) / 4;
                checks++;
                if ({psel, paddr, pwdata} !== ((k % 2 == 0) ? {2'b01, 3'd1, 8'h11} : {2'b10, 3'd2, 8'h22})) begin
                    errors++; $display("FAIL b2b_setup: cycle %0d got psel=%b addr=%0d wd=%h exp owner m%0d", t, psel, paddr, pwdata, k % 2);
                end
            end
        end
        checks++;
        if (ndone != 4) begin
            errors++; $display("FAIL b2b_count: got %0d dones exp 4", ndone);
        end
        clear_inputs();
        @(negedge pclk);
    endtask

    task automatic test_read_wait();
        do_reset();
        m1_req = 1; m1_write = 0; m1_bank = 0; m1_addr = 3'd6; pready = 0; prdata = 8'hF0;
        for (int t = 1; t <= 9; t++) begin
            @(negedge pclk);
            checks++;
            if ({m1_done, m0_done} !== ((t == 6) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL rd_done: cycle %0d got m1/m0=%b exp %b", t, {m1_done, m0_done}, (t == 6) ? 2'b10 : 2'b00);
            end
            checks++;
            if (rdata !== ((t >= 6) ? 8'h3C : 8'h00)) begin
                errors++; $display("FAIL rd_data: cycle %0d got %h exp %h", t, rdata, (t >= 6) ? 8'h3C : 8'h00);
            end
            if (t == 6) begin
                checks++;
                if (m1_err !== 1'b0) begin
                    errors++; $display("FAIL rd_err: got %b exp 0", m1_err);
                end
                m1_req = 0;
            end
            pready = (t >= 5);
            prdata = (t == 5) ? 8'h3C : (8'hF0 ^ 8'(t));
        end
        clear_inputs();
    endtask

    // Runs without reset so rdata still holds the previous read
    task automatic test_timeout();
        int pen = 0;
        int dc = -1;
        m0_req = 1; m0_write = 0; m0_bank = 1; m0_addr = 3'd3; pready = 0; prdata = 8'h99;
        for (int t = 1; t <= 30; t++) begin
            @(negedge pclk);
            if (penable) pen++;
            if (m0_done && dc < 0) begin
                dc = t;
                checks++;
                if ({m0_err, psel, penable, rdata} !== {1'b1, 2'b00, 1'b0, 8'h3C}) begin
                    errors++; $display("FAIL to_resp: got err=%b psel=%b en=%b rdata=%h exp 1/00/0/3c", m0_err, psel, penable, rdata);
                end
                m0_req = 0;
            end
        end
        checks++;
        if (pen != TO || dc != 2 + TO) begin
            errors++; $display("FAIL to_len: penable cycles %0d done cycle %0d exp %0d and %0d", pen, dc, TO, 2 + TO);
        end
        clear_inputs();
    endtask

    task automatic test_bad_bank();
        do_reset();
        m1_req3 = 1; m1_bank3 = 2'd3; pready = 1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge pclk);
            if (t < 3) begin
                checks++;
                if (psel3 !== 3'b000) begin
                    errors++; $display("FAIL bb_psel: cycle %0d got %b exp 000", t, psel3);
                end
                checks++;
                if ({m1_done3, m1_err3, m0_done3} !== ((t == 1) ? 3'b110 : 3'b000)) begin
                    errors++; $display("FAIL bb_done: cycle %0d got %b exp %b", t, {m1_done3, m1_err3, m0_done3}, (t == 1) ? 3'b110 : 3'b000);
                end
            end else begin
                checks++;
                if (psel3 !== 3'b100) begin
                    errors++; $display("FAIL bb_top_bank: got %b exp 100", psel3);
                end
            end
            if (t == 1) m1_req3 = 0;
            if (t == 2) begin m1_req3 = 1; m1_bank3 = 2'd2; end
        end
        m1_req3 = 0;
        repeat (3) @(negedge pclk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_req = 1; m0_write = 0; m0_bank = 0; pready = 1; prdata = 8'h5A;
        repeat (3) @(negedge pclk);
        m0_req = 0;
        @(negedge pclk);   // IDLE
        checks++;
        if (rdata !== 8'h5A) begin
            errors++; $display("FAIL rm_pre: got rdata %h exp 5a", rdata);
        end
        m1_req = 1; m1_write = 0; m1_bank = 0; pready = 0;
        repeat (2) @(negedge pclk);   // ACCESS
        checks++;
        if (penable !== 1'b1) begin
            errors++; $display("FAIL rm_access: got penable %b exp 1", penable);
        end
        presetn = 0;
        @(negedge pclk);
        checks++;
        if ({psel, penable, rdata, m0_done, m1_done} !== 13'd0) begin
            errors++; $display("FAIL rm_abort: got %h exp 0", {psel, penable, rdata, m0_done, m1_done});
        end
        presetn = 1; m0_req = 1; m0_bank = 1; pready = 1;
        @(negedge pclk);
        checks++;
        if ({psel, m0_done, m1_done} !== 4'b1000) begin
            errors++; $display("FAIL rm_tie: got psel=%b done=%b exp psel=10 (m0 first) no done", psel, {m0_done, m1_done});
        end
        repeat (2) @(negedge pclk);
        checks++;
        if ({m0_done, m1_done} !== 2'b10) begin
            errors++; $display("FAIL rm_next: got m0/m1 done %b exp 10", {m0_done, m1_done});
        end
        clear_inputs();
        @(negedge pclk);
    endtask

    // Randomized traffic against a transfer-level schedule model
    task automatic test_random();
        bit         act [2];
        logic       f_wr [2], f_bk [2];
        logic [2:0] f_ad [2];
        logic [7:0] f_wd [2];
        int         f_wt [2];
        int         last = 1, owner = 0, grant_t = -100, done_t = -100, next_idle = 0, lw = 0;
        logic       l_wr = 0, l_bk = 0, l_err = 0;
        logic [2:0] l_ad = 0;
        logic [7:0] l_wd = 0, exp_rdata = 0, pend = 0;
        logic [1:0] e_psel;
        bit         win, acc;
        do_reset();
        act[0] = 0; act[1] = 0;
        for (int t = 0; t < 500; t++) begin
            if (t == done_t && !l_err && !l_wr) exp_rdata = pend;
            win = (t > grant_t) && (t < done_t);
            acc = (t > grant_t + 1) && (t < done_t);
            e_psel = win ? (2'b01 << l_bk) : 2'b00;
            checks++;
            if ({psel, penable, pwrite, paddr, pwdata} !== {e_psel, acc, win & l_wr, win ? l_ad : 3'd0, win ? l_wd : 8'd0}) begin
                errors++; $display("FAIL rnd_apb: cycle %0d got psel=%b en=%b wr=%b addr=%0d wd=%h exp %b/%b/%b/%0d/%h", t, psel, penable, pwrite, paddr, pwdata, e_psel, acc, win & l_wr, win ? l_ad : 3'd0, win ? l_wd : 8'd0);
            end
            checks++;
            if ({m0_done, m0_err, m1_done, m1_err} !== {t == done_t && owner == 0, t == done_t && owner == 0 && l_err, t == done_t && owner == 1, t == done_t && owner == 1 && l_err}) begin
                errors++; $display("FAIL rnd_resp: cycle %0d got m0 d/e=%b%b m1 d/e=%b%b exp owner m%0d done_cycle %0d err %b", t, m0_done, m0_err, m1_done, m1_err, owner, done_t, l_err);
            end
            checks++;
            if (rdata !== exp_rdata) begin
                errors++; $display("FAIL rnd_rdata: cycle %0d got %h exp %h", t, rdata, exp_rdata);
            end
            if (t == done_t) act[owner] = 0;
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(0, 2) != 0) begin
                    act[i] = 1;
                    f_wr[i] = 1'($urandom); f_bk[i] = 1'($urandom); f_ad[i] = 3'($urandom); f_wd[i] = 8'($urandom);
                    f_wt[i] = ($urandom_range(0, 6) == 0) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, 4));
                end else if (act[i] && i == owner && t > grant_t && t < done_t) begin
                    f_wr[i] = 1'($urandom); f_bk[i] = 1'($urandom); f_ad[i] = 3'($urandom); f_wd[i] = 8'($urandom);
                end
            end
            if (t >= next_idle && (act[0] || act[1])) begin
                owner = (act[0] && act[1]) ? 1 - last : (act[1] ? 1 : 0);
                last = owner; grant_t = t;
                l_wr = f_wr[owner]; l_bk = f_bk[owner]; l_ad = f_ad[owner]; l_wd = f_wd[owner]; lw = f_wt[owner];
                l_err = (lw >= TO);
                done_t = l_err ? t + 2 + TO : t + 3 + lw;
                next_idle = done_t + 1;
            end
            m0_req = act[0]; m0_write = f_wr[0]; m0_bank = f_bk[0]; m0_addr = f_ad[0]; m0_wdata = f_wd[0];
            m1_req = act[1]; m1_write = f_wr[1]; m1_bank = f_bk[1]; m1_addr = f_ad[1]; m1_wdata = f_wd[1];
            prdata = 8'($urandom);
            if (t > grant_t + 1 && t < done_t) pready = (t >= grant_t + 2 + lw);
            else pready = 1'($urandom);
            if (t == grant_t + 2 + lw && !l_err) pend = prdata;
            @(negedge pclk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_wait();
        test_timeout();
        test_bad_bank();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_bank_arbiter.md
Name: apb_bank_arbiter

Overview:
- Arbitrates two APB requesters for the shared GPIO bank bus. Requester 0 is the SPI-to-APB bridge side; requester 1 is an on-chip sequencer or scanner.
- Grants one transfer at a time, round-robin. Runs a correct APB SETUP/ACCESS sequence to the selected bank, using one-hot psel.
- Bounds wait states with a timeout, then returns done/err/rdata to the owning requester.

Parameters:
- BANK_NUM, 2: number of GPIO banks and psel width. Must be >= 2.
- DATA_WIDTH, 8: APB data width.
- ADDR_WIDTH, 3: APB register address width.
- TIMEOUT, 16: maximum ACCESS cycles without pready before abort. Must be >= 1.

Ports:
- pclk  in  1  single clock for all logic.
- presetn  in  1  synchronous, active-low reset.
- m0_req, m1_req  in  1  transfer request; held until that requester's done.
- m0_write, m1_write  in  1  1 = write, 0 = read.
- m0_bank, m1_bank  in  BIW  bank index, where BIW = max(1, clog2(BANK_NUM)).
- m0_addr, m1_addr  in  ADDR_WIDTH  register address.
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  error flag, valid only with done.
- rdata  out  DATA_WIDTH  last successful read data; shared by both requesters.
- psel  out  BANK_NUM  one-hot bank select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  read data from the selected bank (banks OR or mux externally).
- pready  in  1  bank ready.

Behaviour:
- Reset (presetn=0 sampled at the pclk rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including rdata.
  - Wait counter goes to 0.
  - Last-grant pointer goes to 1, so m0 wins the first tie.
  - Reset mid-transfer aborts silently: psel and penable are 0 next cycle, and no done pulse is issued.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - Samples requests. With one req, grant that requester. With both, grant the one not granted last.
  - Latch owner, write, bank, addr and wdata into internal registers. The requester's inputs are not reused after this.
  - If bank >= BANK_NUM: go to RESP with err=1 and no APB activity.
  - Otherwise go to SETUP. In SETUP: psel[bank]=1, penable=0, and paddr/pwrite/pwdata carry the latched values.
  - The pointer updates on grant.
- SETUP -> ACCESS unconditionally. penable=1; psel, paddr, pwrite and pwdata are held stable.
- ACCESS, sampling each edge:
  - If pready=1:
    - Go to RESP with err=0.
    - For a read, rdata <= prdata. For a write, rdata is unchanged.
    - psel and penable go to 0.
  - Else if the wait counter equals TIMEOUT-1:
    - Go to RESP with err=1.
    - psel and penable go to 0; rdata is unchanged.
  - Else the counter increments.
  - pready=1 on the final allowed cycle wins over timeout.
  - The counter clears on entry to SETUP.
- RESP:
  - The owner's done=1 for exactly one cycle, and its err reflects the result. The non-owner's done and err stay 0.
  - No arbitration takes place in RESP; the next state is IDLE. This gives the requester one cycle to drop req.
- Latency: req in IDLE at cycle 0 -> SETUP at 1 -> ACCESS at 2 -> RESP with done at 3+W, where W is the number of wait cycles.
  - Minimum period is 4 cycles per transfer.
  - Out-of-range bank: done+err at cycle 1.
- Deasserting req mid-transfer has no effect: the transfer completes and done still pulses.
- Requester input changes after grant are ignored.
- With both requesters held high continuously, grants alternate m0, m1, m0, ...

Decomposition:
- Shared package (gpio_exp_pkg):
  - State enum: IDLE, SETUP, ACCESS, RESP.
  - BIW width function.
  - Default TIMEOUT constant.
- One sub-module, apb_rr_arb2:
  - Inputs: req[1:0] and an enable (IDLE).
  - Outputs: one-hot gnt[1:0].
  - Contains the last-grant register and its reset value.

Test Plan:
- m0 write, bank=1, addr=5, wdata=8'hA5, pready tied 1:
  - cycle 1: psel=2'b10, penable=0, paddr=5, pwdata=A5.
  - cycle 2: penable=1.
  - cycle 3: m0_done=1, m0_err=0.
  - cycle 4: IDLE with all APB outputs 0.
- m0_req and m1_req both asserted after reset and held: done order is m0, m1, m0, m1. Each transfer uses the correct latched addr/data, with 4 cycles between done pulses.
- m1 read, bank=0, pready low for 3 ACCESS cycles then high, prdata=8'h3C: m1_done at cycle 6, m1_err=0, rdata=3C and held afterwards.
- pready stuck 0, TIMEOUT=16:
  - penable stays high exactly 16 cycles, then psel/penable drop.
  - m0_done=1 with m0_err=1.
  - rdata keeps its previous value.
- BANK_NUM=3, m1 request with bank=3: psel stays 0 throughout; m1_done=1 with m1_err=1 at cycle 1.
- presetn=0 for one cycle while in ACCESS:
  - Next cycle psel=0, penable=0, no done pulse, rdata=0.
  - A subsequent m0/m1 tie grants m0.
